ahb_rr_arbiter: RTL and testbench
=================================

# ahb_rr_arbiter

- Round-robin AHB bus arbiter for up to N_MASTERS requesters sharing one AHB slave fabric.
- Grants exactly one master at a time and holds the grant until the selected slave completes the transfer with OKAY or ERROR.
- Drives the slave-select code and address-phase/data-phase owner IDs that steer the address, write-data and read-data muxes.
- A watchdog recovers the bus if a slave stalls hready.

## Interface

- N_MASTERS, 3, number of requesters (2..4)
- SEL_W, 4, width of each master's slave-select code
- TIMEOUT, 16, max consecutive hready-low cycles in a grant before forced release (≥2)
- hclk  in  1  bus clock, all state on rising edge
- hresetn  in  1  asynchronous, active-low reset
- hreq  in  N_MASTERS  per-master bus request, level
- sel_in  in  N_MASTERS*SEL_W  per-master decoded slave select, master i at bits [i*SEL_W +: SEL_W]
- hready  in  1  ready from the currently selected slave
- hresp  in  1  response from the selected slave, 0 = OKAY, 1 = ERROR
- hgrant  out  N_MASTERS  one-hot grant, registered
- sel  out  SEL_W  slave select of the granted master, 0 when idle, registered
- hmaster  out  2  address-phase owner index, registered
- hmaster_d  out  2  data-phase owner index, updated when hready=1
- resp_err  out  1  one-cycle pulse: transfer ended with ERROR
- timeout_err  out  1  one-cycle pulse: watchdog fired

## Operation

**Reset values (asynchronous, immediate on hresetn low, including mid-transfer):**
- hgrant=0, sel=0, hmaster=0, hmaster_d=0, resp_err=0, timeout_err=0.
- State=IDLE, last_owner=N_MASTERS-1, wd_cnt=0.

**States:** IDLE, GRANT, RECOVER.

**Round-robin pick:**
- Winner is the first i with hreq[i]=1, scanning i = last_owner+1 … wrapping modulo N_MASTERS.
- After reset, master 0 has highest priority.

**IDLE:**
- If any hreq is high, go to GRANT with owner=winner.
- hgrant[owner]=1, sel=sel_in[owner], hmaster=owner, last_owner=owner.

**GRANT:**
- done = hready & ~hresp; err = hready & hresp.
- On done or err:
  - If any hreq other than the current owner's is high, hand over directly to GRANT with the new winner. The current owner is excluded from the scan for this decision, so it cannot win twice back-to-back while others wait.
  - Otherwise, if the owner still requests, re-grant the owner.
  - Otherwise go to IDLE, with hgrant=0 and sel=0.
- err additionally pulses resp_err in the cycle after err is sampled.
- Dropping hreq[owner] while granted does not release the grant; release happens only on done, err or timeout.
- sel is re-sampled from sel_in[owner] every cycle in GRANT.

**Watchdog:**
- wd_cnt increments each GRANT cycle with hready=0.
- Clears on hready=1 and on every state change.
- When wd_cnt reaches TIMEOUT-1 with hready still 0, go to RECOVER.

**RECOVER:**
- Exactly one cycle: hgrant=0, sel=0, timeout_err=1.
- Then IDLE. last_owner keeps the timed-out master, so it has lowest priority next.

**Width rules:**
- Indices use 2 bits; values ≥ N_MASTERS are never produced.
- wd_cnt is clog2(TIMEOUT) bits and saturates, never wraps.

## Timing

- Request to grant: hreq sampled high in IDLE → hgrant high at the next rising edge (1-cycle latency).
- Completion to handover: done/err sampled → the new hgrant appears at the next edge and the old grant drops on the same edge. There are no idle bus cycles and never two grants high at once.
- hmaster_d <= hmaster on every edge with hready=1; it holds otherwise.
- resp_err and timeout_err are registered single-cycle pulses.
- Simultaneous done and watchdog terminal count: done wins and the watchdog does not fire.

## Structure

- Shared package ahb_arb_pkg holds:
  - state enum (IDLE=2'b00, GRANT=2'b01, RECOVER=2'b10)
  - HRESP_OKAY=1'b0 and HRESP_ERROR=1'b1
  - owner index type (2 bits)
- Sub-module ahb_rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, last index, exclude-enable.
  - Outputs: valid and winner index.
  - Reused by future bridge-side arbitration.

## Test plan

- Reset, then hreq=3'b111 held, every transfer completes with hready=1/hresp=0 → grants rotate 0→1→2→0, one transfer each, no gap cycles, hgrant always one-hot.
- hreq=3'b010, sel_in for master 1 = 4'h5, hready low 3 cycles then high → hgrant=3'b010 and sel=4'h5 one cycle after request, held 4 cycles, then IDLE with sel=0.
- Master 0 granted, slave returns hready=1/hresp=1 while hreq[2]=1 → resp_err pulses once, grant moves to master 2 on the next edge, hmaster_d=0 for that data phase.
- Master 2 granted, hready held 0 for 16 cycles → RECOVER for 1 cycle with timeout_err=1 and hgrant=0, then IDLE. With all requesting, the next grant goes to master 0.
- Master 1 drops hreq mid-transfer with hready=0 → hgrant[1] stays high until hready=1.
- hresetn asserted low while master 1 is granted and hready=0 → all outputs 0 immediately. After release with hreq=3'b110, master 1 is granted first.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_arb_pkg
// Shared types and constants for the AHB round-robin arbiter and its
// priority picker.
//   arb_state_t : arbiter FSM state encoding
//   HRESP_*     : AHB response encodings used by the arbiter
//   owner_t     : 2-bit master index (supports up to four requesters)
// ---------------------------------------------------------------------------
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RECOVER = 2'b10
    } arb_state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef logic [1:0] owner_t;

endpackage

// File: rtl/ahb_rr_pick.sv
// ---------------------------------------------------------------------------
// ahb_rr_pick
// Combinational round-robin priority picker. Scans the request vector
// starting just after 'last' and wrapping modulo N; the first set request
// wins. With 'excl' high, the request of master 'last' is ignored so the
// previous owner cannot win again while others are waiting.
// Ports:
//   req   in  N   request vector
//   last  in  2   index of the most recent owner (lowest priority)
//   excl  in  1   mask out req[last] from the scan
//   valid out 1   at least one (unmasked) request present
//   win   out 2   winning master index
// ---------------------------------------------------------------------------
module ahb_rr_pick
    import ahb_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    input  owner_t       last,
    input  logic         excl,
    output logic         valid,
    output owner_t       win
);

    logic [N-1:0] req_m_s;
    owner_t       idx_s;
    logic         hit_s;

    // Remove the previous owner's request when exclusion is requested.
    always_comb begin
        req_m_s = req;
        for (int i = 0; i < N; i++) begin
            req_m_s[i] = req[i] & ~(excl & (last == owner_t'(i)));
        end
    end

    // Rotating scan: last+1, last+2, ... last+N (the last one is 'last' itself).
    always_comb begin
        valid = 1'b0;
        win   = 2'd0;
        idx_s = 2'd0;
        hit_s = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx_s = owner_t'((int'(last) + k) % N);
            hit_s = req_m_s[idx_s] & ~valid;
            valid = valid | hit_s;
            win   = hit_s ? idx_s : win;
        end
    end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_rr_arbiter
// Round-robin AHB arbiter. One master is granted at a time; the grant is
// held until the selected slave ends the transfer with OKAY or ERROR
// (hready=1). A watchdog forces a one-cycle RECOVER state if hready stays
// low for TIMEOUT consecutive cycles of a grant.
// Ports:
//   hclk, hresetn   clock, asynchronous active-low reset
//   hreq        in  N_MASTERS        per-master level request
//   sel_in      in  N_MASTERS*SEL_W  per-master slave select
//   hready      in  1                ready from selected slave
//   hresp       in  1                0 = OKAY, 1 = ERROR
//   hgrant      out N_MASTERS        one-hot grant (registered)
//   sel         out SEL_W            granted master's select, 0 when idle
//   hmaster     out 2                address-phase owner
//   hmaster_d   out 2                data-phase owner (follows hmaster on hready)
//   resp_err    out 1                pulse: transfer ended with ERROR
//   timeout_err out 1                pulse: watchdog fired
// ---------------------------------------------------------------------------
module ahb_rr_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int N_MASTERS = 3,
    parameter int SEL_W     = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                       hclk,
    input  logic                       hresetn,
    input  logic [N_MASTERS-1:0]       hreq,
    input  logic [N_MASTERS*SEL_W-1:0] sel_in,
    input  logic                       hready,
    input  logic                       hresp,
    output logic [N_MASTERS-1:0]       hgrant,
    output logic [SEL_W-1:0]           sel,
    output owner_t                     hmaster,
    output owner_t                     hmaster_d,
    output logic                       resp_err,
    output logic                       timeout_err
);

    localparam int                WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]   WD_MAX  = {WD_W{1'b1}};

    arb_state_t             state_r, state_s;
    owner_t                 last_owner_r, last_owner_s;
    logic [WD_W-1:0]        wd_cnt_r, wd_cnt_s;
    logic [N_MASTERS-1:0]   hgrant_s;
    logic [SEL_W-1:0]       sel_s;
    owner_t                 hmaster_s;
    logic                   resp_err_s;
    logic                   timeout_err_s;
    logic                   pick_valid_s;
    owner_t                 pick_win_s;
    logic                   excl_s;
    logic [SEL_W-1:0]       sel_arr_s [N_MASTERS];

    function automatic logic [N_MASTERS-1:0] to_onehot(input owner_t idx);
        logic [N_MASTERS-1:0] v;
        v      = {N_MASTERS{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    for (genvar g = 0; g < N_MASTERS; g++) begin : g_sel_unpack
        assign sel_arr_s[g] = sel_in[g*SEL_W +: SEL_W];
    end

    // While granted, the current owner is excluded so a waiting master wins.
    assign excl_s = (state_r == GRANT);

    ahb_rr_pick #(
        .N     (N_MASTERS)
    ) u_pick (
        .req   (hreq),
        .last  (last_owner_r),
        .excl  (excl_s),
        .valid (pick_valid_s),
        .win   (pick_win_s)
    );

    // Next-state, watchdog and next-output computation.
    always_comb begin
        state_s       = state_r;
        last_owner_s  = last_owner_r;
        wd_cnt_s      = {WD_W{1'b0}};
        hgrant_s      = hgrant;
        sel_s         = sel;
        hmaster_s     = hmaster;
        resp_err_s    = 1'b0;
        timeout_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_s      = GRANT;
                    hgrant_s     = to_onehot(pick_win_s);
                    sel_s        = sel_arr_s[pick_win_s];
                    hmaster_s    = pick_win_s;
                    last_owner_s = pick_win_s;
                end else begin
                    hgrant_s = {N_MASTERS{1'b0}};
                    sel_s    = {SEL_W{1'b0}};
                end
            end
            GRANT: begin
                sel_s = sel_arr_s[hmaster];
                if (hready) begin
                    // Transfer ended (OKAY or ERROR); done takes priority over the watchdog.
                    resp_err_s = (hresp == HRESP_ERROR);
                    if (pick_valid_s) begin
                        hgrant_s     = to_onehot(pick_win_s);
                        sel_s        = sel_arr_s[pick_win_s];
                        hmaster_s    = pick_win_s;
                        last_owner_s = pick_win_s;
                    end else if (hreq[hmaster]) begin
                        hgrant_s = to_onehot(hmaster);
                    end else begin
                        state_s  = IDLE;
                        hgrant_s = {N_MASTERS{1'b0}};
                        sel_s    = {SEL_W{1'b0}};
                    end
                end else if (wd_cnt_r == WD_LAST) begin
                    state_s       = RECOVER;
                    hgrant_s      = {N_MASTERS{1'b0}};
                    sel_s         = {SEL_W{1'b0}};
                    timeout_err_s = 1'b1;
                end else begin
                    wd_cnt_s = (wd_cnt_r == WD_MAX) ? wd_cnt_r : wd_cnt_r + WD_W'(1);
                end
            end
            RECOVER: begin
                state_s  = IDLE;
                hgrant_s = {N_MASTERS{1'b0}};
                sel_s    = {SEL_W{1'b0}};
            end
            default: begin
                state_s  = IDLE;
                hgrant_s = {N_MASTERS{1'b0}};
                sel_s    = {SEL_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_r      <= IDLE;
            last_owner_r <= owner_t'(N_MASTERS - 1);
            wd_cnt_r     <= {WD_W{1'b0}};
            hgrant       <= {N_MASTERS{1'b0}};
            sel          <= {SEL_W{1'b0}};
            hmaster      <= 2'd0;
            hmaster_d    <= 2'd0;
            resp_err     <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_r      <= state_s;
            last_owner_r <= last_owner_s;
            wd_cnt_r     <= wd_cnt_s;
            hgrant       <= hgrant_s;
            sel          <= sel_s;
            hmaster      <= hmaster_s;
            resp_err     <= resp_err_s;
            timeout_err  <= timeout_err_s;
            if (hready) begin
                hmaster_d <= hmaster;
            end else begin
                hmaster_d <= hmaster_d;
            end
        end
    end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
module tb_ahb_rr_arbiter;

    logic        hclk;
    logic        hresetn;
    logic [2:0]  hreq;
    logic [11:0] sel_in;
    logic        hready;
    logic        hresp;
    logic [2:0]  hgrant;
    logic [3:0]  sel;
    logic [1:0]  hmaster;
    logic [1:0]  hmaster_d;
    logic        resp_err;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    ahb_rr_arbiter #(
        .N_MASTERS (3),
        .SEL_W     (4),
        .TIMEOUT   (16)
    ) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .hreq        (hreq),
        .sel_in      (sel_in),
        .hready      (hready),
        .hresp       (hresp),
        .hgrant      (hgrant),
        .sel         (sel),
        .hmaster     (hmaster),
        .hmaster_d   (hmaster_d),
        .resp_err    (resp_err),
        .timeout_err (timeout_err)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic [2:0]  hreq;
        logic [11:0] sel_in;
        logic        hready;
        logic        hresp;
        logic [2:0]  g;
        logic [3:0]  s;
        logic [1:0]  hm;
        logic [1:0]  hmd;
        logic        re;
        logic        te;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        // Rotation with all requesting (m0 sel=1, m1 sel=2, m2 sel=3)
        vecs[0]  = '{3'b111, 12'h321, 1'b1, 1'b0, 3'b001, 4'h1, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{3'b111, 12'h321, 1'b1, 1'b0, 3'b010, 4'h2, 2'd1, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{3'b111, 12'h321, 1'b1, 1'b0, 3'b100, 4'h3, 2'd2, 2'd1, 1'b0, 1'b0};
        vecs[3]  = '{3'b111, 12'h321, 1'b1, 1'b0, 3'b001, 4'h1, 2'd0, 2'd2, 1'b0, 1'b0};
        vecs[4]  = '{3'b111, 12'h321, 1'b1, 1'b0, 3'b010, 4'h2, 2'd1, 2'd0, 1'b0, 1'b0};
        // Release to IDLE, stay idle
        vecs[5]  = '{3'b000, 12'h321, 1'b1, 1'b0, 3'b000, 4'h0, 2'd1, 2'd1, 1'b0, 1'b0};
        vecs[6]  = '{3'b000, 12'h321, 1'b1, 1'b0, 3'b000, 4'h0, 2'd1, 2'd1, 1'b0, 1'b0};
        // Master 1 alone, sel 5, waits 3 cycles (request dropped, sel re-sampled to 6)
        vecs[7]  = '{3'b010, 12'h351, 1'b0, 1'b0, 3'b010, 4'h5, 2'd1, 2'd1, 1'b0, 1'b0};
        vecs[8]  = '{3'b000, 12'h351, 1'b0, 1'b0, 3'b010, 4'h5, 2'd1, 2'd1, 1'b0, 1'b0};
        vecs[9]  = '{3'b000, 12'h361, 1'b0, 1'b0, 3'b010, 4'h6, 2'd1, 2'd1, 1'b0, 1'b0};
        vecs[10] = '{3'b000, 12'h361, 1'b0, 1'b0, 3'b010, 4'h6, 2'd1, 2'd1, 1'b0, 1'b0};
        vecs[11] = '{3'b000, 12'h361, 1'b1, 1'b0, 3'b000, 4'h0, 2'd1, 2'd1, 1'b0, 1'b0};
        // Master 0 granted, ERROR response with master 2 waiting
        vecs[12] = '{3'b001, 12'h361, 1'b1, 1'b0, 3'b001, 4'h1, 2'd0, 2'd1, 1'b0, 1'b0};
        vecs[13] = '{3'b101, 12'h361, 1'b1, 1'b1, 3'b100, 4'h3, 2'd2, 2'd0, 1'b1, 1'b0};

        hresetn = 1'b1;
        hreq    = 3'b000;
        sel_in  = 12'h000;
        hready  = 1'b0;
        hresp   = 1'b0;
        #1 hresetn = 1'b0;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_hgrant", 32'(hgrant), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_hmaster", 32'(hmaster), 32'd0);
        chk("rst_hmaster_d", 32'(hmaster_d), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge hclk);
        hresetn = 1'b1;
        #1;

        for (int i = 0; i < 14; i++) begin
            hreq   = vecs[i].hreq;
            sel_in = vecs[i].sel_in;
            hready = vecs[i].hready;
            hresp  = vecs[i].hresp;
            step();
            chk($sformatf("v%0d_hgrant", i), 32'(hgrant), 32'(vecs[i].g));
            chk($sformatf("v%0d_sel", i), 32'(sel), 32'(vecs[i].s));
            chk($sformatf("v%0d_hmaster", i), 32'(hmaster), 32'(vecs[i].hm));
            chk($sformatf("v%0d_hmaster_d", i), 32'(hmaster_d), 32'(vecs[i].hmd));
            chk($sformatf("v%0d_resp_err", i), 32'(resp_err), 32'(vecs[i].re));
            chk($sformatf("v%0d_timeout_err", i), 32'(timeout_err), 32'(vecs[i].te));
        end

        // Watchdog: master 2 granted, hready stuck low
        hreq   = 3'b111;
        hready = 1'b0;
        hresp  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("wd%0d_hgrant", i), 32'(hgrant), 32'b100);
            chk($sformatf("wd%0d_timeout_err", i), 32'(timeout_err), 32'd0);
            chk($sformatf("wd%0d_resp_err", i), 32'(resp_err), 32'd0);
        end
        step();
        chk("recover_hgrant", 32'(hgrant), 32'd0);
        chk("recover_sel", 32'(sel), 32'd0);
        chk("recover_timeout_err", 32'(timeout_err), 32'd1);
        step();
        chk("post_recover_hgrant", 32'(hgrant), 32'd0);
        chk("post_recover_timeout_err", 32'(timeout_err), 32'd0);
        step();
        chk("after_timeout_hgrant", 32'(hgrant), 32'b001);
        chk("after_timeout_hmaster", 32'(hmaster), 32'd0);
        chk("after_timeout_hmaster_d", 32'(hmaster_d), 32'd0);

        // Handover to master 1, then master 1 drops request while stalled
        hreq   = 3'b010;
        hready = 1'b1;
        step();
        chk("ho1_hgrant", 32'(hgrant), 32'b010);
        chk("ho1_sel", 32'(sel), 32'h6);
        hreq   = 3'b000;
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("drop%0d_hgrant", i), 32'(hgrant), 32'b010);
        end
        hready = 1'b1;
        step();
        chk("drop_release_hgrant", 32'(hgrant), 32'd0);
        chk("drop_release_sel", 32'(sel), 32'd0);

        // Asynchronous reset while master 1 is granted and stalled
        hreq   = 3'b010;
        hready = 1'b1;
        step();
        chk("pre_rst_hgrant", 32'(hgrant), 32'b010);
        hready = 1'b0;
        step();
        chk("pre_rst_hold", 32'(hgrant), 32'b010);
        #2 hresetn = 1'b0;
        #1;
        chk("arst_hgrant", 32'(hgrant), 32'd0);
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_hmaster", 32'(hmaster), 32'd0);
        chk("arst_hmaster_d", 32'(hmaster_d), 32'd0);
        chk("arst_resp_err", 32'(resp_err), 32'd0);
        chk("arst_timeout_err", 32'(timeout_err), 32'd0);
        hreq = 3'b110;
        @(negedge hclk);
        hresetn = 1'b1;
        step();
        chk("post_rst_hgrant", 32'(hgrant), 32'b010);
        chk("post_rst_hmaster", 32'(hmaster), 32'd1);
        chk("post_rst_sel", 32'(sel), 32'h6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
